// File: rtl/brr_block_decoder.sv
// BRR block decoder: takes one 9-byte block per request and streams its 16
// decoded 15-bit samples, keeping two-sample filter history per channel.

module brr_sample_calc #(
  parameter int CLAMP = 1
) (
  input  logic [3:0]  nib,
  input  logic [3:0]  shift,
  input  logic [1:0]  filter,
  input  logic [14:0] p1,
  input  logic [14:0] p2,
  output logic [14:0] pcm
);
  logic signed [17:0] s, x, t1, t2, sum;
  logic signed [23:0] a, b;

  always_comb begin
    s = {{14{nib[3]}}, nib};
    a = {{9{p1[14]}}, p1};
    b = {{9{p2[14]}}, p2};
    if (shift <= 4'd12) x = (s <<< shift) >>> 1;
    else                x = nib[3] ? -18'sd2048 : 18'sd0;
    t1 = '0;
    t2 = '0;
    // each term floors on its own before the sum
    case (filter)
      2'd1: t1 = 18'((a * 24'sd15) >>> 4);
      2'd2: begin
        t1 = 18'((a * 24'sd61) >>> 5);
        t2 = 18'((b * 24'sd15) >>> 4);
      end
      2'd3: begin
        t1 = 18'((a * 24'sd115) >>> 6);
        t2 = 18'((b * 24'sd13) >>> 4);
      end
      default: ;
    endcase
    sum = x + t1 - t2;
    if (CLAMP != 0 && sum > 18'sd32767)       pcm = 15'h7fff;
    else if (CLAMP != 0 && sum < -18'sd32768) pcm = 15'h0000;
    else                                      pcm = sum[14:0];
  end
endmodule

module brr_hist_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        wr,
  input  logic [14:0] p1_in,
  input  logic [14:0] p2_in,
  output logic [14:0] p1,
  output logic [14:0] p2
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1 <= '0;
      p2 <= '0;
    end else if (clr) begin
      p1 <= '0;
      p2 <= '0;
    end else if (wr) begin
      p1 <= p1_in;
      p2 <= p2_in;
    end
  end
endmodule

module brr_block_decoder #(
  parameter int CH_NUM = 8,
  parameter int CH_W   = $clog2(CH_NUM),
  parameter int CLAMP  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            blk_valid,
  output logic            blk_ready,
  input  logic [CH_W-1:0] blk_ch,
  input  logic [7:0]      blk_header,
  input  logic [63:0]     blk_data,
  input  logic            hist_clr,
  input  logic [CH_W-1:0] hist_clr_ch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [14:0]     out_pcm,
  output logic [CH_W-1:0] out_ch,
  output logic [3:0]      out_idx,
  output logic            out_last,
  output logic            out_end,
  output logic            out_loop,
  output logic            busy
);
  typedef enum logic {IDLE, DECODE} state_t;
  state_t state, state_nxt;

  logic [CH_NUM-1:0][14:0] st_p1, st_p2;
  logic [3:0]  cur_shift;
  logic [1:0]  cur_filter;
  logic        cur_loop, cur_end;
  logic [63:0] cur_data;
  logic [14:0] p1, p2;

  logic        accept, take, last_take, clr_active, clr_new;
  logic [63:0] c_data;
  logic [3:0]  c_pos, c_nib, c_shift;
  logic [1:0]  c_filter;
  logic [14:0] c_p1, c_p2, c_pcm;

  assign blk_ready  = (state == IDLE);
  assign busy       = (state == DECODE);
  assign accept     = blk_valid & blk_ready;
  assign take       = busy & out_valid & out_ready;
  assign last_take  = take & (out_idx == 4'd15);
  assign clr_active = busy & hist_clr & (hist_clr_ch == out_ch);
  assign clr_new    = hist_clr & (hist_clr_ch == blk_ch);

  // One calculator: in IDLE it sees the offered block and stored history so
  // sample 0 is registered on the accept edge; in DECODE it sees sample idx+1.
  always_comb begin
    if (busy) begin
      c_data   = cur_data;
      c_pos    = 4'd14 - out_idx;
      c_shift  = cur_shift;
      c_filter = cur_filter;
      c_p1     = p1;
      c_p2     = p2;
    end else begin
      c_data   = blk_data;
      c_pos    = 4'd15;
      c_shift  = blk_header[7:4];
      c_filter = blk_header[3:2];
      c_p1     = clr_new ? 15'd0 : st_p1[blk_ch];
      c_p2     = clr_new ? 15'd0 : st_p2[blk_ch];
    end
    c_nib = c_data[{c_pos, 2'b00} +: 4];
  end

  brr_sample_calc #(.CLAMP(CLAMP)) u_calc (
    .nib    (c_nib),
    .shift  (c_shift),
    .filter (c_filter),
    .p1     (c_p1),
    .p2     (c_p2),
    .pcm    (c_pcm)
  );

  genvar g;
  generate
    for (g = 0; g < CH_NUM; g++) begin : g_hist
      brr_hist_slot u_slot (
        .clk   (clk),
        .reset (reset),
        .clr   (hist_clr && hist_clr_ch == CH_W'(g)),
        .wr    (last_take && out_ch == CH_W'(g)),
        .p1_in (p1),
        .p2_in (p2),
        .p1    (st_p1[g]),
        .p2    (st_p2[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (blk_valid) state_nxt = DECODE;
      DECODE:  if (clr_active || last_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_shift  <= '0;
      cur_filter <= '0;
      cur_loop   <= 1'b0;
      cur_end    <= 1'b0;
      cur_data   <= '0;
      p1         <= '0;
      p2         <= '0;
      out_valid  <= 1'b0;
      out_pcm    <= '0;
      out_ch     <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      out_end    <= 1'b0;
      out_loop   <= 1'b0;
    end else if (accept) begin
      cur_shift  <= blk_header[7:4];
      cur_filter <= blk_header[3:2];
      cur_loop   <= blk_header[1];
      cur_end    <= blk_header[0];
      cur_data   <= blk_data;
      p1         <= c_pcm;
      p2         <= c_p1;
      out_valid  <= 1'b1;
      out_pcm    <= c_pcm;
      out_ch     <= blk_ch;
      out_idx    <= '0;
      out_last   <= 1'b0;
      out_end    <= 1'b0;
      out_loop   <= 1'b0;
    end else if (clr_active || last_take) begin
      // abort drops the working history; the store slot is zeroed instead
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      out_end    <= 1'b0;
      out_loop   <= 1'b0;
    end else if (take) begin
      p2         <= p1;
      p1         <= c_pcm;
      out_pcm    <= c_pcm;
      out_idx    <= out_idx + 4'd1;
      out_last   <= (out_idx == 4'd14);
      out_end    <= cur_end & (out_idx == 4'd14);
      out_loop   <= cur_loop & (out_idx == 4'd14);
    end
  end
endmodule
